// File: rtl/keypad_buffer.sv
// Keypad event buffer: debounces the scanner's level key code into one event per press
// and queues events in a show-ahead FIFO with a sticky overflow flag.
module keypad_buffer #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [7:0]               code,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t          state;
    logic [7:0]      cand;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            do_pop;
    logic            do_push;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [7:0]      mem [DEPTH];

    // cand is never zero while debouncing, so a match implies a real key
    assign push = (state == DEBOUNCE) && (code == cand) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (code != '0) begin
                        cand  <= code;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (code == '0) begin
                        state <= IDLE;
                    end else if (code != cand) begin
                        cand <= code;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (code == '0) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else if (code != cand) begin
                        cand  <= code;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                RELEASE: begin
                    if (code == cand) begin
                        state <= HELD;
                    end else if (code != '0) begin
                        cand  <= code;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = rd_en && !empty;
    // a pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (push && full && !do_pop) overflow <= 1'b1;
            else if (clr_ovf)            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= code;
    end

endmodule

// File: tb/tb_keypad_buffer.sv
// Bench for keypad_buffer: directed scenarios plus random key traffic, checked every
// cycle against a run-length debounce model and a queue-based FIFO model.
module tb_keypad_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SC    = 8;

    logic       clk;
    logic       nRST;
    logic [7:0] code;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int nerr   = 0;
    int nchecks = 0;

    // reference model state
    logic [7:0] run_val;
    int         run_len;
    logic [7:0] latched;
    logic [7:0] q[$];
    logic       m_ovf;

    keypad_buffer #(.DEPTH(DEPTH), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .nRST(nRST), .code(code), .rd_en(rd_en), .clr_ovf(clr_ovf),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run_val = 8'h00;
        run_len = 0;
        latched = 8'h00;
        q.delete();
        m_ovf = 1'b0;
    endtask

    // An event is a nonzero key seen for SC+1 consecutive samples while no key is latched;
    // a latched key is forgotten on any other key or after SC+1 consecutive zero samples.
    task automatic model_edge(input logic [7:0] c, input logic r, input logic co);
        logic ev;
        logic setov;
        if (c == run_val) run_len++;
        else begin
            run_val = c;
            run_len = 1;
        end
        ev = 1'b0;
        if (c != 8'h00 && c != latched) latched = 8'h00;
        if (c == 8'h00 && run_len == SC + 1) latched = 8'h00;
        if (c != 8'h00 && latched == 8'h00 && run_len == SC + 1) begin
            ev = 1'b1;
            latched = c;
        end
        setov = 1'b0;
        if (r && q.size() > 0) void'(q.pop_front());
        if (ev) begin
            if (q.size() < DEPTH) q.push_back(c);
            else setov = 1'b1;
        end
        if (setov) m_ovf = 1'b1;
        else if (co) m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        chk("rd_data",  rd_data,  (q.size() > 0) ? q[0] : 8'h00);
        chk("empty",    {7'd0, empty},    {7'd0, q.size() == 0});
        chk("full",     {7'd0, full},     {7'd0, q.size() == DEPTH});
        chk("count",    {5'd0, count},    8'(q.size()));
        chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    endtask

    task automatic step(input logic [7:0] c, input logic r, input logic co);
        code    = c;
        rd_en   = r;
        clr_ovf = co;
        @(posedge clk);
        model_edge(c, r, co);
        #1;
        check_outputs();
    endtask

    task automatic hold(input logic [7:0] c, input int n);
        repeat (n) step(c, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [7:0] c);
        hold(c, 10);
        hold(8'h00, 10);
    endtask

    task automatic drain();
        repeat (DEPTH + 1) step(8'h00, 1'b1, 1'b0);
        hold(8'h00, 10);
    endtask

    task automatic do_reset(input logic [7:0] c);
        code    = c;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_rd_data",  rd_data, 8'h00);
        chk("rst_empty",    {7'd0, empty}, 8'h01);
        chk("rst_full",     {7'd0, full}, 8'h00);
        chk("rst_count",    {5'd0, count}, 8'h00);
        chk("rst_overflow", {7'd0, overflow}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nRST = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] k;
        int unsigned len;
        nRST = 1'b0;
        code = 8'h00;
        rd_en = 1'b0;
        clr_ovf = 1'b0;
        model_reset();
        do_reset(8'h00);

        // clean press: push lands on edge 8 counting the first nonzero sample as edge 0
        hold("5", 8);
        chk("pre_push_empty", {7'd0, empty}, 8'h01);
        step("5", 1'b0, 1'b0);
        chk("push_5", rd_data, "5");
        hold("5", 11);
        hold(8'h00, 20);
        hold("5", 12);
        hold(8'h00, 12);
        chk("two_presses", {5'd0, count}, 8'h02);
        drain();

        // bounce during press and during hold
        for (int i = 0; i < 5; i++) begin
            hold("3", 3);
            hold(8'h00, 3);
        end
        hold("3", 10);
        hold(8'h00, 4);
        hold("3", 6);
        hold(8'h00, 12);
        chk("bounce_count", {5'd0, count}, 8'h01);
        chk("bounce_key", rd_data, "3");
        drain();

        // direct key change, then ordered pops
        hold("1", 12);
        hold("2", 12);
        chk("head_1", rd_data, "1");
        step("2", 1'b1, 1'b0);
        chk("head_2", rd_data, "2");
        step("2", 1'b1, 1'b0);
        chk("pop_empty", {7'd0, empty}, 8'h01);
        chk("pop_rd_zero", rd_data, 8'h00);
        hold(8'h00, 12);

        // overflow on fifth press, then clear
        press("A"); press("B"); press("C"); press("D"); press("#");
        chk("ovf_full", {7'd0, full}, 8'h01);
        chk("ovf_flag", {7'd0, overflow}, 8'h01);
        chk("ovf_head", rd_data, "A");
        step(8'h00, 1'b0, 1'b1);
        chk("ovf_clr", {7'd0, overflow}, 8'h00);

        // full FIFO: push and pop on the same edge
        hold("E", 8);
        step("E", 1'b1, 1'b0);
        chk("sim_count", {5'd0, count}, 8'h04);
        chk("sim_head", rd_data, "B");
        chk("sim_no_ovf", {7'd0, overflow}, 8'h00);
        hold(8'h00, 10);
        drain();
        step(8'h00, 1'b1, 1'b0);
        chk("pop_on_empty", {5'd0, count}, 8'h00);

        // drop coinciding with clr_ovf: set wins
        press("W"); press("X"); press("Y"); press("Z");
        hold("Q", 8);
        step("Q", 1'b0, 1'b1);
        chk("set_wins", {7'd0, overflow}, 8'h01);
        hold(8'h00, 10);
        step(8'h00, 1'b0, 1'b1);
        drain();

        // reset with two entries queued and a key mid-debounce, key held through reset
        press("8"); press("9");
        hold("7", 3);
        do_reset("7");
        hold("7", 8);
        chk("post_rst_empty", {7'd0, empty}, 8'h01);
        step("7", 1'b0, 1'b0);
        chk("post_rst_key", rd_data, "7");
        hold("7", 5);
        hold(8'h00, 10);
        chk("post_rst_count", {5'd0, count}, 8'h01);

        // random key traffic
        for (int s = 0; s < 150; s++) begin
            case ($urandom_range(0, 4))
                0, 1:    k = 8'h00;
                2:       k = "1";
                3:       k = "2";
                default: k = "3";
            endcase
            len = $urandom_range(1, 12);
            repeat (len) step(k, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            if (s == 75) do_reset(k);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
